// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    // FETCH issues requests normally; DROP waits out a request whose word is stale.
    typedef enum logic {
        FETCH = 1'b0,
        DROP  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory request bus, instruction delivery bus and redirect for the fetch stage.
interface fetch_unit_if;
    import fetch_pkg::*;

    logic               mem_req;
    logic [PC_W-1:0]    mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;

    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_pc,
        input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_pc,
        output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit_fifo.sv
// Small synchronous FIFO of {pc, instr} entries with flush; pointers carry
// one extra wrap bit so full and empty are distinguishable.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    fetch_entry_t mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

    // Storage and pointers; flush rewinds both pointers to empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && count != CNT_FULL) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && count != '0) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, requests words from instruction
// memory, buffers them with their PCs, and restarts on redirect. A request
// already on the bus is never withdrawn, so a redirect during a wait parks the
// new target until the stale word comes back.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    fetch_state_e    state, state_n;
    logic [PC_W-1:0] fetch_pc, fetch_pc_n;
    logic [PC_W-1:0] pend_pc, pend_pc_n;
    logic            run;
    logic [AW:0]     count;
    fetch_entry_t    head, push_data;
    logic            push, pop, flush, fire;
    logic [PC_W-1:0] target;

    // Requests start one edge after reset release, then follow FIFO space.
    assign bus.mem_req     = run && (state == DROP || count != CNT_FULL);
    assign bus.mem_addr    = fetch_pc;
    assign bus.instr_valid = (count != '0);
    assign bus.instr       = head.instr;
    assign bus.instr_pc    = head.pc;

    assign fire      = bus.mem_req && bus.mem_ack;
    assign target    = bus.redirect_pc & ~32'd3;
    assign push_data = '{pc: fetch_pc, instr: bus.mem_rdata};

    // State, PC and pending-target registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            pend_pc  <= '0;
            run      <= 1'b0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            pend_pc  <= pend_pc_n;
            run      <= 1'b1;
        end
    end

    // Next-state logic; redirect outranks push and pop.
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        pend_pc_n  = pend_pc;
        push       = 1'b0;
        flush      = bus.redirect;
        pop        = bus.instr_valid && bus.instr_ready && !bus.redirect;
        unique case (state)
            FETCH: begin
                if (bus.redirect) begin
                    if (!bus.mem_req || fire) begin
                        fetch_pc_n = target;
                    end else begin
                        state_n   = DROP;
                        pend_pc_n = target;
                    end
                end else if (fire) begin
                    push       = 1'b1;
                    fetch_pc_n = fetch_pc + PC_STEP;
                end
            end
            DROP: begin
                if (bus.redirect) pend_pc_n = target;
                if (fire) begin
                    fetch_pc_n = bus.redirect ? target : pend_pc;
                    state_n    = FETCH;
                end
            end
            default: state_n = FETCH;
        endcase
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .count     (count),
        .head      (head)
    );
endmodule
